posit_decode: RTL and testbench

// Two-operand posit field decoder; the stage directly upstream of posit_scalar.
// - Accepts raw posit operands a, b plus opcode through a valid/ready handshake.
// - Extracts sign, zero/NaR flags, magnitude, signed regime, exponent and left-aligned fraction.
// - Two-stage pipeline: S1 handles special values and magnitude. S2 handles regime run-length and field extraction.

---
 rtl/posit_decode.sv | 215 +++++++++++++++++++++
 tb/tb_posit_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode.sv
// posit_decode
// Two-operand posit field decoder feeding posit_scalar. Two pipeline stages:
//   S1: zero / NaR detection, sign and two's-complement magnitude.
//   S2: regime run-length scan, exponent and fraction extraction.
// Operands a and b are decoded independently; opcode rides along unchanged.
//
// Handshake (both ports): a beat transfers on a rising clk edge where
// valid and ready are both high. A producer holds valid and its data stable
// until the transfer. ready may depend combinationally on the stage state and
// out_ready, never on in_valid.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   in_valid / in_ready      input handshake for a, b, opcode
//   opcode [1:0], a, b       operation code and raw posit operands
//   out_valid / out_ready    output handshake
//   opcode_out               opcode aligned with the decoded pair
//   x_zero_out, x_exception  operand is zero / NaR (x in {a,b})
//   x_sign                   sign bit, 0 for zero and NaR
//   x_regime                 signed regime k
//   x_exponent               exponent bits, truncated LSBs read as 0
//   x_fraction               fraction bits, MSB-aligned, no hidden bit
//   x_abs                    magnitude, 0 for NaR
//
// Optional build macro POSIT_DECODE_NAR_COUNT_EN adds:
//   count_clr (in)           synchronous clear of nar_count
//   nar_count [15:0] (out)   saturating count of emitted pairs holding a NaR
module posit_decode #(
  parameter int posit_width = 8,
  parameter int es = 1,
  localparam int regime_width = $clog2(posit_width) + 1,
  localparam int frac_width = posit_width - es - 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              opcode,
  input  logic [posit_width-1:0]  a,
  input  logic [posit_width-1:0]  b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              opcode_out,
  output logic                    a_zero_out,
  output logic                    b_zero_out,
  output logic                    a_sign,
  output logic                    b_sign,
  output logic [regime_width-1:0] a_regime,
  output logic [regime_width-1:0] b_regime,
  output logic [es-1:0]           a_exponent,
  output logic [es-1:0]           b_exponent,
  output logic [frac_width-1:0]   a_fraction,
  output logic [frac_width-1:0]   b_fraction,
  output logic [posit_width-1:0]  a_abs,
  output logic [posit_width-1:0]  b_abs,
  output logic                    a_exception,
`ifdef POSIT_DECODE_NAR_COUNT_EN
  output logic                    b_exception,
  input  logic                    count_clr,
  output logic [15:0]             nar_count
`else
  output logic                    b_exception
`endif
);

  localparam int N  = posit_width;
  localparam int RW = regime_width;
  localparam int FW = frac_width;
  localparam int DW = RW + es + FW;
  localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

  // Regime/exponent/fraction from the magnitude without its (always 0) MSB.
  // The whole word is shifted left past the run and its terminator; what
  // remains is exponent then fraction. For an all-ones run the shift clears
  // everything, which gives the required zero exponent and fraction.
  function automatic logic [DW-1:0] decode_fields(input logic [N-2:0] body);
    logic          r0;
    logic          run;
    logic [RW-1:0] m;
    logic [RW-1:0] k;
    logic [N-2:0]  shifted;
    r0  = body[N-2];
    run = 1'b1;
    m   = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == r0)) m = m + 1'b1;
      else                        run = 1'b0;
    end
    k       = r0 ? (m - 1'b1) : (~m + 1'b1);
    shifted = body << (m + 1'b1);
    return {k, shifted[N-2 -: es], shifted[N-2-es -: FW]};
  endfunction

  // Index 0 = operand a, index 1 = operand b.
  logic [1:0][N-1:0] x_in;
  assign x_in = {b, a};

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s2_load, accept;

  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;

  // ---------------- stage 1 ----------------
  logic [1:0][N-1:0] s1_abs_d, s1_abs_q;
  logic [1:0]        s1_sign_d, s1_sign_q;
  logic [1:0]        s1_zero_d, s1_zero_q;
  logic [1:0]        s1_nar_d, s1_nar_q;
  logic [1:0]        s1_op_q;

  always_comb begin
    s1_abs_d  = '0;
    s1_sign_d = '0;
    s1_zero_d = '0;
    s1_nar_d  = '0;
    for (int i = 0; i < 2; i++) begin
      s1_zero_d[i] = (x_in[i] == '0);
      s1_nar_d[i]  = (x_in[i] == NAR_PAT);
      s1_sign_d[i] = x_in[i][N-1] & ~s1_nar_d[i];
      // NaR negates to itself; report magnitude 0 for it instead.
      if (!s1_nar_d[i])
        s1_abs_d[i] = x_in[i][N-1] ? (~x_in[i] + 1'b1) : x_in[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_abs_q   <= '0;
      s1_sign_q  <= '0;
      s1_zero_q  <= '0;
      s1_nar_q   <= '0;
      s1_op_q    <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (accept) begin
        s1_abs_q  <= s1_abs_d;
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        s1_nar_q  <= s1_nar_d;
        s1_op_q   <= opcode;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [1:0][DW-1:0] s2_fields_d, s2_fields_q;
  logic [1:0][N-1:0]  s2_abs_q;
  logic [1:0]         s2_sign_q, s2_zero_q, s2_nar_q;
  logic [1:0]         s2_op_q;

  always_comb begin
    s2_fields_d = '0;
    for (int i = 0; i < 2; i++) begin
      // Zero and NaR carry no meaningful fields; force them to 0.
      if (!(s1_zero_q[i] | s1_nar_q[i]))
        s2_fields_d[i] = decode_fields(s1_abs_q[i][N-2:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q  <= 1'b0;
      s2_fields_q <= '0;
      s2_abs_q    <= '0;
      s2_sign_q   <= '0;
      s2_zero_q   <= '0;
      s2_nar_q    <= '0;
      s2_op_q     <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_fields_q <= s2_fields_d;
        s2_abs_q    <= s1_abs_q;
        s2_sign_q   <= s1_sign_q;
        s2_zero_q   <= s1_zero_q;
        s2_nar_q    <= s1_nar_q;
        s2_op_q     <= s1_op_q;
      end
    end
  end

  // ---------------- outputs ----------------
  assign out_valid   = s2_valid_q;
  assign opcode_out  = s2_op_q;
  assign a_zero_out  = s2_zero_q[0];
  assign b_zero_out  = s2_zero_q[1];
  assign a_sign      = s2_sign_q[0];
  assign b_sign      = s2_sign_q[1];
  assign a_exception = s2_nar_q[0];
  assign b_exception = s2_nar_q[1];
  assign a_abs       = s2_abs_q[0];
  assign b_abs       = s2_abs_q[1];
  assign {a_regime, a_exponent, a_fraction} = s2_fields_q[0];
  assign {b_regime, b_exponent, b_fraction} = s2_fields_q[1];

`ifdef POSIT_DECODE_NAR_COUNT_EN
  logic [15:0] nar_count_q;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      nar_count_q <= '0;
    else if (count_clr)
      nar_count_q <= '0;
    else if (s2_valid_q && out_ready && (|s2_nar_q) && (nar_count_q != 16'hFFFF))
      nar_count_q <= nar_count_q + 1'b1;
  end

  assign nar_count = nar_count_q;
`endif

endmodule

// File: tb/tb_posit_decode.sv
// Directed bench for posit_decode (N=8, es=1) with hand-computed expectations.
module tb_posit_decode;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] opcode, opcode_out;
  logic [7:0] a, b, a_abs, b_abs;
  logic       a_zero_out, b_zero_out, a_sign, b_sign, a_exception, b_exception;
  logic [3:0] a_regime, b_regime, a_fraction, b_fraction;
  logic [0:0] a_exponent, b_exponent;
`ifdef POSIT_DECODE_NAR_COUNT_EN
  logic        count_clr;
  logic [15:0] nar_count;
`endif

  posit_decode #(.posit_width(8), .es(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
    .a_zero_out(a_zero_out), .b_zero_out(b_zero_out),
    .a_sign(a_sign), .b_sign(b_sign),
    .a_regime(a_regime), .b_regime(b_regime),
    .a_exponent(a_exponent), .b_exponent(b_exponent),
    .a_fraction(a_fraction), .b_fraction(b_fraction),
    .a_abs(a_abs), .b_abs(b_abs),
    .a_exception(a_exception),
`ifdef POSIT_DECODE_NAR_COUNT_EN
    .b_exception(b_exception),
    .count_clr(count_clr),
    .nar_count(nar_count)
`else
    .b_exception(b_exception)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];   // {opcode, a_abs, b_abs}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_a(input string t, input logic sg, input logic zr, input logic ex,
                         input logic [3:0] rg, input logic [0:0] e, input logic [3:0] fr,
                         input logic [7:0] ab);
    chk({t, ".a_sign"},     32'(a_sign),      32'(sg));
    chk({t, ".a_zero"},     32'(a_zero_out),  32'(zr));
    chk({t, ".a_exc"},      32'(a_exception), 32'(ex));
    chk({t, ".a_regime"},   32'(a_regime),    32'(rg));
    chk({t, ".a_exponent"}, 32'(a_exponent),  32'(e));
    chk({t, ".a_fraction"}, 32'(a_fraction),  32'(fr));
    chk({t, ".a_abs"},      32'(a_abs),       32'(ab));
  endtask

  task automatic check_b(input string t, input logic sg, input logic zr, input logic ex,
                         input logic [3:0] rg, input logic [0:0] e, input logic [3:0] fr,
                         input logic [7:0] ab);
    chk({t, ".b_sign"},     32'(b_sign),      32'(sg));
    chk({t, ".b_zero"},     32'(b_zero_out),  32'(zr));
    chk({t, ".b_exc"},      32'(b_exception), 32'(ex));
    chk({t, ".b_regime"},   32'(b_regime),    32'(rg));
    chk({t, ".b_exponent"}, 32'(b_exponent),  32'(e));
    chk({t, ".b_fraction"}, 32'(b_fraction),  32'(fr));
    chk({t, ".b_abs"},      32'(b_abs),       32'(ab));
  endtask

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge on which the pair was accepted.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] op);
    logic ok;
    int   budget;
    a = av; b = bv; opcode = op; in_valid = 1'b1;
    budget = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      budget++;
    end while (!ok && budget < 100);
    #1 in_valid = 1'b0;
    chk("send.accepted", 32'(ok), 32'd1);
  endtask

  // Accept one pair into an empty pipeline and check the 2-cycle latency.
  task automatic run_one(input string t, input logic [7:0] av, input logic [7:0] bv,
                         input logic [1:0] op);
    send(av, bv, op);
    chk({t, ".lat1_out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({t, ".lat2_out_valid"}, 32'(out_valid), 32'd1);
    chk({t, ".opcode_out"},     32'(opcode_out), 32'(op));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0;
`ifdef POSIT_DECODE_NAR_COUNT_EN
    count_clr = 1'b0;
`endif
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    check_a("rst", 0, 0, 0, 4'h0, 1'b0, 4'h0, 8'h00);
    check_b("rst", 0, 0, 0, 4'h0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
`ifdef POSIT_DECODE_NAR_COUNT_EN
    chk("rst.nar_count", 32'(nar_count), 32'd0);
`endif

    // 1: 0x5A -> k=0 e=1 f=1010 ; 0x40 -> k=0 e=0 f=0
    run_one("t1", 8'h5A, 8'h40, 2'b00);
    check_a("t1", 0, 0, 0, 4'h0, 1'b1, 4'b1010, 8'h5A);
    check_b("t1", 0, 0, 0, 4'h0, 1'b0, 4'b0000, 8'h40);

    // 2: zero and NaR
    run_one("t2", 8'h00, 8'h80, 2'b01);
    check_a("t2", 0, 1, 0, 4'h0, 1'b0, 4'h0, 8'h00);
    check_b("t2", 0, 0, 1, 4'h0, 1'b0, 4'h0, 8'h00);
`ifdef POSIT_DECODE_NAR_COUNT_EN
    @(posedge clk); #1;
    chk("t2.nar_count", 32'(nar_count), 32'd1);
    count_clr = 1'b1;
    @(posedge clk); #1 count_clr = 1'b0;
    chk("t2.nar_clr", 32'(nar_count), 32'd0);
`endif

    // 3: extreme regimes: 0x7F -> +6 ; 0x01 -> -6
    run_one("t3", 8'h7F, 8'h01, 2'b10);
    check_a("t3", 0, 0, 0, 4'h6, 1'b0, 4'h0, 8'h7F);
    check_b("t3", 0, 0, 0, 4'hA, 1'b0, 4'h0, 8'h01);

    // 4: negative operands: -0xC0 = 0x40 ; -0xA6 = 0x5A
    run_one("t4", 8'hC0, 8'hA6, 2'b11);
    check_a("t4", 1, 0, 0, 4'h0, 1'b0, 4'h0,    8'h40);
    check_b("t4", 1, 0, 0, 4'h0, 1'b1, 4'b1010, 8'h5A);

    // 5: backpressure with 4 pairs
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_q.push_back({2'd0, 8'h5A, 8'h40});
    exp_q.push_back({2'd1, 8'h40, 8'h5A});
    exp_q.push_back({2'd2, 8'h7F, 8'h01});
    exp_q.push_back({2'd3, 8'h00, 8'h00});
    fork
      begin
        send(8'h5A, 8'h40, 2'd0);
        send(8'hC0, 8'hA6, 2'd1);
        send(8'h7F, 8'h01, 2'd2);
        send(8'h80, 8'h00, 2'd3);
      end
      begin
        int budget;
        logic [17:0] exp_v;
        @(posedge clk); @(posedge clk); #2;
        chk("t5.full_in_ready",  32'(in_ready),  32'd0);
        chk("t5.full_out_valid", 32'(out_valid), 32'd1);
        chk("t5.full_a_abs",     32'(a_abs),     32'h5A);
        repeat (3) @(posedge clk);
        #2;
        chk("t5.hold_in_ready", 32'(in_ready), 32'd0);
        chk("t5.hold_pair", {14'd0, opcode_out, a_abs, b_abs}, {14'd0, 2'd0, 8'h5A, 8'h40});
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
          if (out_valid) begin
            exp_v = exp_q.pop_front();
            chk("t5.pair", {14'd0, opcode_out, a_abs, b_abs}, {14'd0, exp_v});
          end
          @(posedge clk); #2;
          budget++;
        end
      end
    join
    chk("t5.drained", 32'(exp_q.size()), 32'd0);

    // 6: async reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h5A, 8'h40, 2'd0);
    send(8'h7F, 8'h01, 2'd2);
    chk("t6.full_out_valid", 32'(out_valid), 32'd1);
    chk("t6.full_in_ready",  32'(in_ready),  32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6.rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6.rst_opcode",    32'(opcode_out), 32'd0);
    check_a("t6.rst", 0, 0, 0, 4'h0, 1'b0, 4'h0, 8'h00);
    check_b("t6.rst", 0, 0, 0, 4'h0, 1'b0, 4'h0, 8'h00);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6.post_out_valid", 32'(out_valid), 32'd0);
    run_one("t6.post", 8'hC0, 8'hA6, 2'd3);
    check_a("t6.post", 1, 0, 0, 4'h0, 1'b0, 4'h0,    8'h40);
    check_b("t6.post", 1, 0, 0, 4'h0, 1'b1, 4'b1010, 8'h5A);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
